// File: rtl/eth_tx_gearbox_66b64b.sv
// 66b->64b TX gearbox: packs one 66-bit block per cycle into a continuous 64-bit
// word stream and paces the PHY with one stall cycle every 33 cycles.
module eth_tx_gearbox_66b64b #(
    parameter int DATA_W = 64,
    parameter int HDR_W  = 2
) (
    input  logic              tx_clk,
    input  logic              tx_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_data_valid,
    input  logic [HDR_W-1:0]  in_hdr,
    input  logic              in_hdr_valid,
    output logic              gbx_req_sync,
    output logic              gbx_req_stall,
    input  logic              gbx_sync,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              err_overflow,
    output logic              err_underrun,
    output logic              err_sync
);

    localparam int SEQ_LEN   = DATA_W / HDR_W + 1;
    localparam int BLK_W     = DATA_W + HDR_W;
    localparam int COMB_W    = 2 * DATA_W;
    localparam logic [5:0] STALL_SEQ = 6'(SEQ_LEN - 1);

    if (DATA_W != 64 || HDR_W != 2) begin : g_param_check
        $error("eth_tx_gearbox_66b64b supports only DATA_W=64, HDR_W=2");
    end

    logic [5:0]        seq_q, seq_d;
    logic [6:0]        res_cnt_q, res_cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_overflow_q, err_overflow_d;
    logic              err_underrun_q, err_underrun_d;
    logic              err_sync_q, err_sync_d;
    logic              req_sync_q, req_sync_d;
    logic              req_stall_q, req_stall_d;

    logic [BLK_W-1:0]  blk;
    logic [COMB_W-1:0] comb;
    logic [DATA_W-1:0] res_eff;
    logic [6:0]        res_cnt_eff;
    logic [5:0]        seq_eff;
    logic              stall, blk_present, accept, realign;

    assign blk         = {in_data, in_hdr};
    assign stall       = (seq_q == STALL_SEQ);
    assign blk_present = in_data_valid & in_hdr_valid;
    assign accept      = blk_present & ~stall;
    assign realign     = accept & gbx_sync & (seq_q != 6'd0);

    // A misaligned sync echo restarts the sequence: the block is packed as if it were first.
    assign res_eff     = realign ? '0 : res_q;
    assign res_cnt_eff = realign ? 7'd0 : res_cnt_q;
    assign seq_eff     = realign ? 6'd0 : seq_q;
    assign comb        = {{DATA_W{1'b0}}, res_eff}
                       | ({{(COMB_W - BLK_W){1'b0}}, blk} << res_cnt_eff);

    always_comb begin
        seq_d          = seq_q;
        res_cnt_d      = res_cnt_q;
        res_d          = res_q;
        out_data_d     = out_data_q;
        out_valid_d    = 1'b0;
        err_overflow_d = 1'b0;
        err_underrun_d = 1'b0;
        err_sync_d     = 1'b0;

        if (stall) begin
            // The 64 leftover header-slip bits form a whole word on their own.
            out_data_d     = res_q;
            out_valid_d    = 1'b1;
            res_d          = '0;
            res_cnt_d      = 7'd0;
            seq_d          = 6'd0;
            err_overflow_d = blk_present;
        end else if (accept) begin
            out_data_d  = comb[DATA_W-1:0];
            out_valid_d = 1'b1;
            res_d       = comb[COMB_W-1:DATA_W];
            res_cnt_d   = res_cnt_eff + 7'd2;
            seq_d       = seq_eff + 6'd1;
            err_sync_d  = realign;
        end else begin
            err_underrun_d = 1'b1;
        end

        req_sync_d  = (seq_d == 6'd0);
        req_stall_d = (seq_d == STALL_SEQ);
    end

    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            seq_q          <= '0;
            res_cnt_q      <= '0;
            res_q          <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            err_overflow_q <= 1'b0;
            err_underrun_q <= 1'b0;
            err_sync_q     <= 1'b0;
            req_sync_q     <= 1'b0;
            req_stall_q    <= 1'b0;
        end else begin
            seq_q          <= seq_d;
            res_cnt_q      <= res_cnt_d;
            res_q          <= res_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            err_overflow_q <= err_overflow_d;
            err_underrun_q <= err_underrun_d;
            err_sync_q     <= err_sync_d;
            req_sync_q     <= req_sync_d;
            req_stall_q    <= req_stall_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign err_overflow  = err_overflow_q;
    assign err_underrun  = err_underrun_q;
    assign err_sync      = err_sync_q;
    assign gbx_req_sync  = req_sync_q;
    assign gbx_req_stall = req_stall_q;

endmodule
